// File: rtl/vbw_pipe_simd_adder.sv
// Two-stage pipelined SIMD adder/subtractor: WIDTH bits split at run time into equal lanes of 8..WIDTH bits.
// Optional unsigned per-lane saturation is compiled in when VBW_SAT_EN is defined.
module vbw_pipe_simd_adder #(
  parameter int WIDTH = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          a,
  input  logic [WIDTH-1:0]          b,
  input  logic [WIDTH/8-1:0]        ci,
  input  logic [$clog2(WIDTH/8):0]  mode,
  input  logic                      sub,
  input  logic                      sat,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          s,
  output logic [WIDTH/8-1:0]        co
);

  localparam int NSEG   = WIDTH / 8;
  localparam int LOG2N  = $clog2(NSEG);
  localparam int MODE_W = LOG2N + 1;

  logic advance;
  assign advance  = out_ready | ~out_valid;
  assign in_ready = advance;

  // seg_mask = segments-per-lane minus one; out-of-range modes collapse to 8-bit lanes
  logic [MODE_W-1:0] mode_eff;
  logic [MODE_W-1:0] seg_mask;
  always_comb begin
    mode_eff = (mode > MODE_W'(LOG2N)) ? MODE_W'(LOG2N) : mode;
    seg_mask = MODE_W'((NSEG >> mode_eff) - 1);
  end

  logic [NSEG*9-1:0] sum0_next, sum1_next;
  logic [NSEG-1:0]   lsb_next, msb_next, cin_next;

  generate
    for (genvar gi = 0; gi < NSEG; gi++) begin : g_seg
      logic [7:0] a_seg, b_seg;
      assign a_seg = a[8*gi +: 8];
      assign b_seg = b[8*gi +: 8] ^ {8{sub}};
      assign sum0_next[9*gi +: 9] = {1'b0, a_seg} + {1'b0, b_seg};
      assign sum1_next[9*gi +: 9] = {1'b0, a_seg} + {1'b0, b_seg} + 9'd1;
      assign lsb_next[gi] = (MODE_W'(gi) & seg_mask) == '0;
      assign msb_next[gi] = (MODE_W'(gi) & seg_mask) == seg_mask;
      assign cin_next[gi] = sub | ci[gi];
    end
  endgenerate

  logic              valid1_reg;
  logic [NSEG*9-1:0] sum0_reg, sum1_reg;
  logic [NSEG-1:0]   lsb_reg, msb_reg, cin_reg;
`ifdef VBW_SAT_EN
  logic              sub1_reg, sat1_reg;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid1_reg <= 1'b0;
      sum0_reg   <= '0;
      sum1_reg   <= '0;
      lsb_reg    <= '0;
      msb_reg    <= '0;
      cin_reg    <= '0;
`ifdef VBW_SAT_EN
      sub1_reg   <= 1'b0;
      sat1_reg   <= 1'b0;
`endif
    end else if (advance) begin
      valid1_reg <= in_valid;
      if (in_valid) begin
        sum0_reg <= sum0_next;
        sum1_reg <= sum1_next;
        lsb_reg  <= lsb_next;
        msb_reg  <= msb_next;
        cin_reg  <= cin_next;
`ifdef VBW_SAT_EN
        sub1_reg <= sub;
        sat1_reg <= sat;
`endif
      end
    end
  end

  // Carry-select chain: the carry is replaced by the lane carry-in at every lane LSB
  logic [WIDTH-1:0] sum_next;
  logic [NSEG-1:0]  cout_next;
  always_comb begin
    logic       c_chain, c_in;
    logic [8:0] seg;
    sum_next  = '0;
    cout_next = '0;
    c_chain   = 1'b0;
    c_in      = 1'b0;
    seg       = '0;
    for (int j = 0; j < NSEG; j++) begin
      c_in = lsb_reg[j] ? cin_reg[j] : c_chain;
      seg  = c_in ? sum1_reg[9*j +: 9] : sum0_reg[9*j +: 9];
      sum_next[8*j +: 8] = seg[7:0];
      cout_next[j]       = seg[8];
      c_chain            = seg[8];
    end
  end

  logic [WIDTH-1:0] s_next;
`ifdef VBW_SAT_EN
  // Walk down from each lane MSB so every segment sees its own lane's carry
  always_comb begin
    logic lane_c;
    s_next = sum_next;
    lane_c = 1'b0;
    for (int j = NSEG - 1; j >= 0; j--) begin
      if (msb_reg[j]) lane_c = cout_next[j];
      if (sat1_reg && (lane_c ^ sub1_reg)) s_next[8*j +: 8] = sub1_reg ? 8'h00 : 8'hFF;
    end
  end
`else
  logic unused_sat;
  assign unused_sat = sat;
  assign s_next     = sum_next;
`endif

  logic             out_valid_reg;
  logic [WIDTH-1:0] s_reg;
  logic [NSEG-1:0]  co_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      s_reg         <= '0;
      co_reg        <= '0;
    end else if (advance) begin
      out_valid_reg <= valid1_reg;
      if (valid1_reg) begin
        s_reg  <= s_next;
        co_reg <= cout_next & msb_reg;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign s         = s_reg;
  assign co        = co_reg;

endmodule
